// File: rtl/adc_responder.sv
// -----------------------------------------------------------------------------
// adc_responder
//   Stands in for the ADC on the request/ready handshake used by the
//   acquisition blocks. It accepts a conversion request pulse and checks that
//   the pulse is at least MIN_REQ_CYCLES wide. After CONV_CYCLES it presents
//   the captured sample with a RDY_CYCLES-wide ready strobe. The sample comes
//   from an internal ramp or from the sample_i port.
//
// Ports
//   clk_i           rising-edge clock
//   reset_n_i       asynchronous reset, active-high (historical name)
//   adc_data_req_i  conversion request from the acquirer
//   src_sel_i       0 = internal ramp, 1 = sample_i
//   sample_i        external sample value
//   adc_data_rdy_o  data-ready strobe
//   adc_data_o      converted sample, held between conversions
//   busy_o          high whenever the responder is not idle
//   err_short_o     1-cycle pulse: request narrower than MIN_REQ_CYCLES
//   err_busy_o      1-cycle pulse: request rise while converting/presenting
//   conv_count_o    completed conversions, wraps at 16 bits
// -----------------------------------------------------------------------------
module adc_responder #(
  parameter int unsigned DATA_W         = 12,
  parameter int unsigned MIN_REQ_CYCLES = 2,
  parameter int unsigned CONV_CYCLES    = 10,
  parameter int unsigned RDY_CYCLES     = 1,
  parameter int unsigned RAMP_STEP      = 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              adc_data_req_i,
  input  logic              src_sel_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              adc_data_rdy_o,
  output logic [DATA_W-1:0] adc_data_o,
  output logic              busy_o,
  output logic              err_short_o,
  output logic              err_busy_o,
  output logic [15:0]       conv_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CONV = 2'd2,
    RDY  = 2'd3
  } state_t;

  localparam logic [3:0]        MIN_W     = 4'(MIN_REQ_CYCLES);
  localparam logic [7:0]        CONV_LAST = 8'(CONV_CYCLES - 1);
  localparam logic [7:0]        RDY_LAST  = 8'(RDY_CYCLES - 1);
  localparam logic [DATA_W-1:0] RAMP_INC  = DATA_W'(RAMP_STEP);

  state_t              state_q, state_d;
  logic                req_q;
  logic                rise;
  logic [3:0]          width_q, width_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   ramp_q, ramp_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rdy_q, rdy_d;
  logic                busy_q;
  logic                err_short_q, err_short_d;
  logic                err_busy_q, err_busy_d;
  logic [15:0]         count_q, count_d;

  // Edge-based start: a level held high across a finished conversion never
  // produces a second rise, so it cannot start another conversion.
  assign rise = adc_data_req_i & ~req_q;

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    ramp_d      = ramp_q;
    data_d      = data_q;
    rdy_d       = rdy_q;
    err_short_d = 1'b0;
    err_busy_d  = 1'b0;
    count_d     = count_q;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = REQ;
          width_d = 4'd1;
        end
      end

      REQ: begin
        if (adc_data_req_i) begin
          if (width_q != 4'hF) begin
            width_d = width_q + 4'd1;
          end
        end else if (width_q >= MIN_W) begin
          hold_d  = src_sel_i ? sample_i : ramp_q;
          cnt_d   = '0;
          width_d = '0;
          state_d = CONV;
        end else begin
          err_short_d = 1'b1;
          width_d     = '0;
          state_d     = IDLE;
        end
      end

      CONV: begin
        err_busy_d = rise;
        if (cnt_q == CONV_LAST) begin
          data_d  = hold_q;
          rdy_d   = 1'b1;
          cnt_d   = '0;
          state_d = RDY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RDY: begin
        // A rise on the exit edge is still seen here and counted as busy.
        err_busy_d = rise;
        if (cnt_q == RDY_LAST) begin
          rdy_d   = 1'b0;
          cnt_d   = '0;
          count_d = count_q + 16'd1;
          ramp_d  = ramp_q + RAMP_INC;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_n_i) begin
    if (reset_n_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      width_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      ramp_q      <= '0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_busy_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= adc_data_req_i;
      width_q     <= width_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      ramp_q      <= ramp_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      busy_q      <= (state_d != IDLE);
      err_short_q <= err_short_d;
      err_busy_q  <= err_busy_d;
      count_q     <= count_d;
    end
  end

  assign adc_data_rdy_o = rdy_q;
  assign adc_data_o     = data_q;
  assign busy_o         = busy_q;
  assign err_short_o    = err_short_q;
  assign err_busy_o     = err_busy_q;
  assign conv_count_o   = count_q;

endmodule
